// File: rtl/cereal_rx_if.sv
// Receive-side bus of the cereal UART: serial pin in, byte and status strobes out.
interface cereal_rx_if;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       parity_err;
  logic       busy;

  modport master (input rx, output data, valid, frame_err, parity_err, busy);
  modport slave  (output rx, input data, valid, frame_err, parity_err, busy);
endinterface

// File: rtl/cereal_rx.sv
// cereal_rx: 8N1 UART receiver with mid-bit sampling from an internal bit-period counter.
// Define CEREAL_RX_PARITY_EN to receive 8E1 frames and report parity_err.
module cereal_rx #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic         sysclk,
  input  logic         rst_n,
  cereal_rx_if.master  bus
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] STOP   = 3'd4;
  localparam logic [2:0] BREAK  = 3'd5;
`ifdef CEREAL_RX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd3;
`endif

  localparam logic [15:0] BIT_RELOAD  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_RELOAD = 16'(HALF_BIT - 1);

  logic [2:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        ferr_q, ferr_d;
  logic        rx_meta_q, rx_s_q;
  logic        tick;
`ifdef CEREAL_RX_PARITY_EN
  logic        par_bad_q, par_bad_d;
  logic        perr_q, perr_d;
`endif

  assign tick = (cnt_q == 16'd0);

  always_comb begin
    state_d = state_q;
    cnt_d   = tick ? cnt_q : cnt_q - 16'd1;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
`ifdef CEREAL_RX_PARITY_EN
    par_bad_d = par_bad_q;
    perr_d    = 1'b0;
`endif
    case (state_q)
      IDLE: if (!rx_s_q) begin
        state_d = START;
        cnt_d   = HALF_RELOAD;
      end
      START: if (tick) begin
        if (!rx_s_q) begin
          state_d = DATA;
          cnt_d   = BIT_RELOAD;
          idx_d   = 3'd0;
        end else begin
          state_d = IDLE;
          cnt_d   = 16'd0;
        end
      end
      DATA: if (tick) begin
        shift_d[idx_q] = rx_s_q;
        cnt_d          = BIT_RELOAD;
        idx_d          = idx_q + 3'd1;
`ifdef CEREAL_RX_PARITY_EN
        if (idx_q == 3'd7) state_d = PARITY;
      end
      PARITY: if (tick) begin
        // Even parity: the parity bit equals the XOR of the eight data bits.
        par_bad_d = rx_s_q ^ (^shift_q);
        cnt_d     = BIT_RELOAD;
        state_d   = STOP;
`else
        if (idx_q == 3'd7) state_d = STOP;
`endif
      end
      // Leave at mid-stop so a start bit right after the stop bit is caught.
      STOP: if (tick) begin
        cnt_d = 16'd0;
        if (rx_s_q) begin
          state_d = IDLE;
`ifdef CEREAL_RX_PARITY_EN
          if (par_bad_q) perr_d = 1'b1;
          else begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end
`else
          data_d  = shift_q;
          valid_d = 1'b1;
`endif
        end else begin
          ferr_d  = 1'b1;
          state_d = BREAK;
        end
      end
      BREAK: if (rx_s_q) state_d = IDLE;
      default: begin
        state_d = IDLE;
        cnt_d   = 16'd0;
      end
    endcase
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= IDLE;
      cnt_q     <= 16'd0;
      idx_q     <= 3'd0;
      shift_q   <= 8'h00;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
`ifdef CEREAL_RX_PARITY_EN
      par_bad_q <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      rx_meta_q <= bus.rx;
      rx_s_q    <= rx_meta_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
`ifdef CEREAL_RX_PARITY_EN
      par_bad_q <= par_bad_d;
      perr_q    <= perr_d;
`endif
    end
  end

  assign bus.data      = data_q;
  assign bus.valid     = valid_q;
  assign bus.frame_err = ferr_q;
  assign bus.busy      = (state_q != IDLE);
`ifdef CEREAL_RX_PARITY_EN
  assign bus.parity_err = perr_q;
`else
  assign bus.parity_err = 1'b0;
`endif

endmodule

// File: doc/cereal_rx.md
Name: cereal_rx

Overview:
- UART receiver: the receive-side counterpart of the team's cereal serial transmitter.
- Frame format: 8N1, LSB first, idle high, one start bit (low), one stop bit (high).
- Samples the asynchronous serial line at mid-bit using an internal bit-period counter; no external clockdiv pulse.
- Presents each received byte with a one-cycle valid strobe. Sits at the board RX pin and feeds byte-level consumers in the sysclk domain.

Parameters:
- CLKS_PER_BIT, 5208, sysclk cycles per bit (50 MHz / 9600 baud). Legal range 4..65535.
- HALF_BIT, CLKS_PER_BIT/2, cycles from start-edge detection to the start-bit mid-sample.

Ports:
- sysclk  in  1  system clock; the only clock.
- rst_n  in  1  asynchronous active-low reset.
- rx  in  1  serial input, asynchronous to sysclk; idle high.
- data  out  8  last correctly framed byte; held until the next good frame.
- valid  out  1  one-cycle strobe: data updated this cycle.
- frame_err  out  1  one-cycle strobe: stop bit sampled low.
- parity_err  out  1  one-cycle strobe: parity mismatch. Constant 0 unless CEREAL_RX_PARITY_EN is defined.
- busy  out  1  high whenever the state machine is not in IDLE.

Behaviour:
- Clock and reset (decided): one clock, sysclk; reset rst_n is asynchronous and active-low.
- Reset values:
  - data=0x00, valid=0, frame_err=0, parity_err=0, busy=0.
  - State=IDLE, counter=0, shift register=0.
  - Both synchronizer flops reset to 1, so releasing reset never looks like a start edge.
- Synchronizer: rx passes through two flops to give rx_s. All decisions use rx_s only.
- Counter: 16-bit down-counter. A "sample tick" occurs in the cycle it equals 0; it reloads on every tick.
- IDLE:
  - rx_s==0 -> go to START, counter=HALF_BIT-1.
- START, on tick:
  - rx_s==0 -> go to DATA, counter=CLKS_PER_BIT-1, bit index=0.
  - rx_s==1 -> treat as a glitch: return to IDLE, no strobe.
- DATA, on each tick:
  - Shift rx_s into bit[index], LSB first. Counter=CLKS_PER_BIT-1.
  - After bit 7 -> go to STOP (or PARITY when the macro is defined).
- STOP, on tick:
  - rx_s==1 -> data<=shift register, valid=1 for exactly one cycle, go to IDLE.
  - rx_s==0 -> frame_err=1 for one cycle, data unchanged, go to BREAK.
  - The return to IDLE happens at mid-stop-bit, so a start bit that immediately follows the stop bit is not missed.
- BREAK: stay until rx_s==1, then go to IDLE. A line held low produces exactly one frame_err, not repeated frames.
- Latency: valid rises between 9.5*CLKS_PER_BIT and 9.5*CLKS_PER_BIT+4 sysclk cycles after the rx falling edge at the pin.
- Strobes: valid and frame_err are never high in the same cycle. All strobes are registered outputs.
- Reset mid-frame: returns to IDLE immediately. data keeps its reset value 0x00; there is no partial-byte strobe.
- Bit-rate tolerance: sender period within ±2% of CLKS_PER_BIT must be received error-free.

Optional Feature:
- Macro: CEREAL_RX_PARITY_EN.
- Defined:
  - Frame is 8E1: an even-parity bit follows bit 7.
  - New state PARITY, one tick long, samples the parity bit.
  - Mismatch -> parity_err=1 for one cycle at the stop-bit tick, in place of valid; data unchanged.
  - Framing check takes priority: if the stop bit is also bad, only frame_err fires.
  - Latency becomes 10.5*CLKS_PER_BIT (+0..4).
- Undefined:
  - No PARITY state; parity_err is tied to 0; frame format is 8N1.

Test Plan (CLKS_PER_BIT=16 unless noted):
- Send 0xA5 as 8N1 at exactly 16 cycles/bit -> one valid pulse, data=0xA5, frame_err=0, busy low after the stop mid-sample.
- Send 0x00 then 0xFF back-to-back with no idle between frames -> two valid pulses 160 cycles apart, data=0x00 then data=0xFF.
- Drive rx low for 6 cycles, then high -> busy pulses, then returns to IDLE; no valid or frame_err. A following 0x3C frame is received correctly.
- Send 0x55 with the stop bit forced low, then hold rx low 100 cycles -> exactly one frame_err, data keeps the previous value. After rx returns high, a 0x81 frame yields valid with data=0x81.
- Assert rst_n low during bit 4 of a frame -> outputs at reset values within the same cycle. After release, the remainder of that frame produces no valid; the next full frame (0x42) is received correctly.
- With CEREAL_RX_PARITY_EN defined: send 0x07 with parity=1 -> valid, data=0x07. Send 0x07 with parity=0 -> parity_err pulse, no valid, data stays 0x07.
